// File: rtl/bus_peripherals.sv
// Memory-mapped peripheral block on the CPU data bus: reloadable timer with
// interrupt, LED register, free-running tick counter and a 4-digit
// multiplexed 7-segment display scanner. Read data is combinational.
`timescale 1ns/1ps
module bus_peripherals #(
  parameter int SCAN_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Device_Read_Data,
  output logic        Irq,
  output logic [7:0]  leds,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LEDS    = 32'h4000_000C;
  localparam logic [31:0] ADDR_DIGITS  = 32'h4000_0010;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

  localparam int              CNT_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  logic [31:0]      th;
  logic [31:0]      tl;
  logic [2:0]       tcon;
  logic [7:0]       ledReg;
  logic [15:0]      digits;
  logic [31:0]      sysTick;
  logic [CNT_W-1:0] scanCnt;
  logic [1:0]       digitIdx;
  logic [1:0]       nextIdx;
  logic [3:0]       anReg;
  logic [7:0]       segReg;

  // Hex nibble to active-low {dp,g,f,e,d,c,b,a}; dp stays dark.
  function automatic logic [7:0] hexToSeg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Full 32-bit address decode; anything else is unmapped.
  logic wrTh, wrTl, wrTcon, wrLeds, wrDigits, wrSysTick;
  assign wrTh      = MemWrite && (MemBus_Address == ADDR_TH);
  assign wrTl      = MemWrite && (MemBus_Address == ADDR_TL);
  assign wrTcon    = MemWrite && (MemBus_Address == ADDR_TCON);
  assign wrLeds    = MemWrite && (MemBus_Address == ADDR_LEDS);
  assign wrDigits  = MemWrite && (MemBus_Address == ADDR_DIGITS);
  assign wrSysTick = MemWrite && (MemBus_Address == ADDR_SYSTICK);

  // Overflow uses the pre-write enable; status sets only with interrupt enable.
  logic overflow;
  logic ovfSet;
  assign overflow = tcon[0] && (tl == 32'hFFFF_FFFF);
  assign ovfSet   = overflow && tcon[1];

  // Combinational read mux, zero when not reading or unmapped.
  always_comb begin
    // NOTE: default assigned first so no path leaves the output unassigned (no latch).
    Device_Read_Data = 32'd0;
    if (MemRead) begin
      case (MemBus_Address)
        ADDR_TH:      Device_Read_Data = th;
        ADDR_TL:      Device_Read_Data = tl;
        ADDR_TCON:    Device_Read_Data = {29'd0, tcon};
        ADDR_LEDS:    Device_Read_Data = {24'd0, ledReg};
        ADDR_DIGITS:  Device_Read_Data = {16'd0, digits};
        ADDR_SYSTICK: Device_Read_Data = sysTick;
        default:      Device_Read_Data = 32'd0;
      endcase
    end
  end

  // Timer: reload/counter/control, CPU writes take priority over counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= 32'd0;
      tl   <= 32'd0;
      tcon <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (wrTh) th <= MemBus_Write_Data;
      if (wrTl)          tl <= MemBus_Write_Data;
      else if (tcon[0])  tl <= overflow ? th : tl + 32'd1;
      if (wrTcon)        tcon <= {MemBus_Write_Data[2] | ovfSet, MemBus_Write_Data[1:0]};
      else if (ovfSet)   tcon[2] <= 1'b1;
    end
  end

  // LED, digit and system tick registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ledReg  <= 8'd0;
      digits  <= 16'd0;
      sysTick <= 32'd0;
    end else begin
      if (wrLeds)   ledReg <= MemBus_Write_Data[7:0];
      if (wrDigits) digits <= MemBus_Write_Data[15:0];
      sysTick <= wrSysTick ? MemBus_Write_Data : sysTick + 32'd1;
    end
  end

  assign nextIdx = digitIdx + 2'd1;

  // Display scanner: dwell SCAN_DIV cycles per digit; an and seg change together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scanCnt  <= '0;
      digitIdx <= 2'd0;
      anReg    <= 4'b1110;
      segReg   <= 8'hC0;
    end else if (scanCnt == SCAN_LAST) begin
      scanCnt  <= '0;
      digitIdx <= nextIdx;
      anReg    <= ~(4'b0001 << nextIdx);
      segReg   <= hexToSeg(digits[{nextIdx, 2'b00} +: 4]);
    end else begin
      scanCnt <= scanCnt + CNT_W'(1);
    end
  end

  assign Irq  = tcon[2];
  assign leds = ledReg;
  assign an   = anReg;
  assign seg  = segReg;

endmodule

// File: tb/tb_bus_peripherals.sv
// Self-checking bench for bus_peripherals: expected values are queued when
// stimulus is applied and popped when the DUT output is sampled.
`timescale 1ns/1ps
module tb_bus_peripherals;

  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_LEDS    = 32'h4000_000C;
  localparam logic [31:0] A_DIGITS  = 32'h4000_0010;
  localparam logic [31:0] A_SYSTICK = 32'h4000_0014;

  logic        clk;
  logic        reset;
  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Device_Read_Data;
  logic        Irq;
  logic [7:0]  leds;
  logic [3:0]  an;
  logic [7:0]  seg;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] expQ[$];

  bus_peripherals #(.SCAN_DIV(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .MemBus_Address   (MemBus_Address),
    .MemBus_Write_Data(MemBus_Write_Data),
    .MemRead          (MemRead),
    .MemWrite         (MemWrite),
    .Device_Read_Data (Device_Read_Data),
    .Irq              (Irq),
    .leds             (leds),
    .an               (an),
    .seg              (seg)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    MemBus_Address    = a;
    MemBus_Write_Data = d;
    MemWrite          = 1'b1;
    tick();
    MemWrite          = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    MemBus_Address = a;
    MemRead        = 1'b1;
    #1;
    d       = Device_Read_Data;
    MemRead = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    logic [31:0] addrs[6];
    addrs = '{A_TH, A_TL, A_TCON, A_LEDS, A_DIGITS, A_SYSTICK};
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    foreach (addrs[i]) expQ.push_back(32'd0);
    foreach (addrs[i]) begin
      busRead(addrs[i], got);
      exp = expQ.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_read addr=%h got=%h exp=%h", addrs[i], got, exp);
      end
    end
    expQ.push_back(32'hE);
    expQ.push_back(32'hC0);
    expQ.push_back(32'h0);
    expQ.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       got = {28'd0, an};
        1:       got = {24'd0, seg};
        2:       got = {31'd0, Irq};
        default: got = {24'd0, leds};
      endcase
      exp = expQ.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_port idx=%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_timer();
    logic [31:0] got, exp, mTl, mTh;
    logic        mIrq;
    mTh = 32'hFFFF_FFFD;
    busWrite(A_TH, mTh);
    busWrite(A_TL, 32'hFFFF_FFFE);
    busWrite(A_TCON, 32'd3);
    mTl  = 32'hFFFF_FFFE;
    mIrq = 1'b0;
    for (int i = 0; i < 7; i++) begin
      expQ.push_back(mTl);
      expQ.push_back({31'd0, mIrq});
      busRead(A_TL, got);
      exp = expQ.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL timer_tl step=%0d got=%h exp=%h", i, got, exp);
      end
      exp = expQ.pop_front();
      total++;
      if ({31'd0, Irq} !== exp) begin
        bad++;
        $display("FAIL timer_irq step=%0d got=%b exp=%b", i, Irq, exp[0]);
      end
      if (mTl == 32'hFFFF_FFFF) begin
        mTl  = mTh;
        mIrq = 1'b1;
      end else begin
        mTl = mTl + 32'd1;
      end
      tick();
    end
    expQ.push_back(32'd7);
    busRead(A_TCON, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL timer_tcon got=%h exp=%h", got, exp);
    end
  endtask

  // Entered with TL=FFFF_FFFF, TCON=7: the next edge overflows.
  task automatic test_irq_conflict();
    logic [31:0] got, exp;
    busWrite(A_TCON, 32'd3);
    expQ.push_back(32'd7);
    expQ.push_back(32'd1);
    expQ.push_back(32'hFFFF_FFFD);
    busRead(A_TCON, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL conflict_tcon got=%h exp=%h", got, exp); end
    exp = expQ.pop_front();
    total++;
    if ({31'd0, Irq} !== exp) begin bad++; $display("FAIL conflict_irq got=%b exp=%b", Irq, exp[0]); end
    busRead(A_TL, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL conflict_tl got=%h exp=%h", got, exp); end
    busWrite(A_TCON, 32'd3);
    expQ.push_back(32'd3);
    expQ.push_back(32'd0);
    busRead(A_TCON, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL clear_tcon got=%h exp=%h", got, exp); end
    exp = expQ.pop_front();
    total++;
    if ({31'd0, Irq} !== exp) begin bad++; $display("FAIL clear_irq got=%b exp=%b", Irq, exp[0]); end
  endtask

  // Timer still enabled here; TL write must beat the increment.
  task automatic test_tl_write();
    logic [31:0] got, exp;
    busWrite(A_TL, 32'd5);
    expQ.push_back(32'd5);
    busRead(A_TL, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL tlwr_load got=%h exp=%h", got, exp); end
    tick();
    expQ.push_back(32'd6);
    busRead(A_TL, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL tlwr_inc got=%h exp=%h", got, exp); end
    busWrite(A_TCON, 32'd0);
    expQ.push_back(32'd7);
    busRead(A_TL, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL tlwr_prewrite_en got=%h exp=%h", got, exp); end
    tick();
    tick();
    expQ.push_back(32'd7);
    busRead(A_TL, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL tlwr_hold got=%h exp=%h", got, exp); end
  endtask

  task automatic test_systick();
    logic [31:0] got, exp;
    busWrite(A_SYSTICK, 32'd100);
    expQ.push_back(32'd100);
    busRead(A_SYSTICK, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL systick_load got=%h exp=%h", got, exp); end
    repeat (3) tick();
    expQ.push_back(32'd103);
    busRead(A_SYSTICK, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL systick_count got=%h exp=%h", got, exp); end
    busWrite(A_SYSTICK, 32'hFFFF_FFFF);
    tick();
    expQ.push_back(32'd0);
    busRead(A_SYSTICK, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL systick_wrap got=%h exp=%h", got, exp); end
  endtask

  task automatic test_rw_same();
    logic [31:0] got, exp;
    MemBus_Address    = A_LEDS;
    MemBus_Write_Data = 32'hA5;
    MemRead           = 1'b1;
    MemWrite          = 1'b1;
    expQ.push_back(32'd0);
    #1;
    got = Device_Read_Data;
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL rw_prewrite got=%h exp=%h", got, exp); end
    tick();
    MemWrite = 1'b0;
    expQ.push_back(32'hA5);
    got = Device_Read_Data;
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL rw_commit got=%h exp=%h", got, exp); end
    MemRead = 1'b0;
    #1;
    expQ.push_back(32'd0);
    got = Device_Read_Data;
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL rw_noread got=%h exp=%h", got, exp); end
  endtask

  task automatic test_unmapped();
    logic [31:0] got, exp;
    logic [31:0] addrs[3];
    addrs = '{32'h4000_0018, 32'h4000_0002, 32'h0000_0010};
    foreach (addrs[i]) begin
      expQ.push_back(32'd0);
      busRead(addrs[i], got);
      exp = expQ.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL unmapped_read addr=%h got=%h exp=%h", addrs[i], got, exp); end
    end
    busWrite(A_LEDS, 32'h1FF);
    busWrite(32'h0000_000C, 32'h12);
    busWrite(32'h4000_000D, 32'h34);
    expQ.push_back(32'hFF);
    exp = expQ.pop_front();
    total++;
    if ({24'd0, leds} !== exp) begin bad++; $display("FAIL leds_trunc got=%h exp=%h", leds, exp); end
    busWrite(A_TCON, 32'hFFFF_FFF8);
    expQ.push_back(32'd0);
    busRead(A_TCON, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL tcon_upper got=%h exp=%h", got, exp); end
  endtask

  task automatic test_display();
    logic [31:0] got, exp;
    logic [3:0]  prevAn;
    logic [3:0]  expAn[4];
    logic [7:0]  expSeg[4];
    bit          found;
    int          cnt;
    expAn  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    expSeg = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
    busWrite(A_DIGITS, 32'hFFFF_4321);
    expQ.push_back(32'h4321);
    busRead(A_DIGITS, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL digits_read got=%h exp=%h", got, exp); end
    found  = 1'b0;
    prevAn = an;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (an == 4'b1110 && prevAn != 4'b1110) found = 1'b1;
      prevAn = an;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL display_sync got=timeout exp=an 1110 within 100 cycles");
      return;
    end
    for (int d = 0; d < 4; d++) begin
      expQ.push_back({28'd0, expAn[d]});
      expQ.push_back({24'd0, expSeg[d]});
      expQ.push_back(32'd16);
      exp = expQ.pop_front();
      total++;
      if ({28'd0, an} !== exp) begin bad++; $display("FAIL display_an digit=%0d got=%b exp=%b", d, an, exp[3:0]); end
      exp = expQ.pop_front();
      total++;
      if ({24'd0, seg} !== exp) begin bad++; $display("FAIL display_seg digit=%0d got=%h exp=%h", d, seg, exp[7:0]); end
      prevAn = an;
      cnt    = 0;
      do begin
        tick();
        cnt++;
      end while (an == prevAn && cnt < 40);
      exp = expQ.pop_front();
      total++;
      if (cnt !== int'(exp)) begin bad++; $display("FAIL display_dwell digit=%0d got=%0d exp=%0d", d, cnt, exp); end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] got, exp;
    logic [31:0] addrs[6];
    bit          found;
    addrs = '{A_TH, A_TL, A_TCON, A_LEDS, A_DIGITS, A_SYSTICK};
    busWrite(A_TH, 32'h1234);
    busWrite(A_TCON, 32'd7);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (an == 4'b1101) found = 1'b1;
      else tick();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL areset_sync got=timeout exp=an 1101 within 100 cycles");
    end
    #3;
    reset = 1'b0;
    #1;
    expQ.push_back(32'hE);
    expQ.push_back(32'hC0);
    expQ.push_back(32'h0);
    expQ.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       got = {28'd0, an};
        1:       got = {24'd0, seg};
        2:       got = {31'd0, Irq};
        default: got = {24'd0, leds};
      endcase
      exp = expQ.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL areset_port idx=%0d got=%h exp=%h", i, got, exp); end
    end
    foreach (addrs[i]) begin
      expQ.push_back(32'd0);
      busRead(addrs[i], got);
      exp = expQ.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL areset_read addr=%h got=%h exp=%h", addrs[i], got, exp); end
    end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset             = 1'b0;
    MemBus_Address    = 32'd0;
    MemBus_Write_Data = 32'd0;
    MemRead           = 1'b0;
    MemWrite          = 1'b0;
    test_reset();
    test_timer();
    test_irq_conflict();
    test_tl_write();
    test_systick();
    test_rw_same();
    test_unmapped();
    test_display();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_peripherals.md
Name: bus_peripherals

Overview:
Memory-mapped peripheral block on the CPU data bus, directly downstream of the CPU's MemBus_* outputs; it produces Device_Read_Data for addresses at 0x4000_0000 and above.
It contains:
- a reloadable 32-bit timer with interrupt
- an 8-bit LED register
- a free-running system tick counter
- a 4-digit multiplexed 7-segment display scanner
All registers update on the rising clk edge. Read data is combinational.

Parameters:
SCAN_DIV, 16, clk cycles each display digit stays active (≥2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
MemBus_Address  input  32  byte address from CPU
MemBus_Write_Data  input  32  store data from CPU
MemRead  input  1  load strobe
MemWrite  input  1  store strobe, sampled at clk edge
Device_Read_Data  output  32  read data to CPU
Irq  output  1  timer interrupt request (level)
leds  output  8  LED register
an  output  4  digit enables, active-low, one-hot-zero
seg  output  8  {dp,g,f,e,d,c,b,a}, active-low; dp always 1

Behaviour:
- Address map (full 32-bit match; any other address, including non-word-aligned ones, is unmapped):
  - 0x4000_0000 TH (reload, RW)
  - 0x4000_0004 TL (counter, RW)
  - 0x4000_0008 TCON[2:0] (RW; upper bits read 0)
  - 0x4000_000C leds[7:0] (RW)
  - 0x4000_0010 DIGITS[15:0] (RW)
  - 0x4000_0014 SYSTICK (RW)
- Reset while reset=0, at any time including mid-scan or mid-count:
  - TH, TL, TCON, leds, DIGITS, SYSTICK, scan counter and digit index all go to 0.
  - an=4'b1110, seg=8'hC0, Irq=0.
- Read path:
  - Device_Read_Data = selected register when MemRead=1 and the address is mapped.
  - Otherwise Device_Read_Data = 0. Zero latency.
- Writes:
  - Take effect at the clk edge when MemWrite=1 and the address is mapped.
  - Writes to unmapped addresses are ignored.
  - Only bits [2:0] of TCON, [7:0] of leds and [15:0] of DIGITS are stored.
- TCON bits: [0] enable, [1] interrupt enable, [2] status. Irq = TCON[2].
- Timer, per cycle when TCON[0]=1:
  - If TL==32'hFFFF_FFFF: TL<=TH, and TCON[2]<=1 if TCON[1]=1.
  - Otherwise TL<=TL+1 (mod 2^32).
  - When TCON[0]=0, TL holds.
- Same-edge conflicts:
  - A CPU write to TL wins over increment/reload.
  - A CPU write to TCON loads bits [1:0] from the write data.
  - TCON[2] <= write_data[2] OR overflow_set_this_cycle, so an interrupt is never lost.
  - The timer enable used for that cycle's count is the pre-write TCON[0].
- SYSTICK:
  - Increments by 1 every cycle and wraps at 2^32.
  - A CPU write loads the written value, and increments continue from it on the next edge.
- Scanner:
  - Counter runs 0..SCAN_DIV-1. On the edge where it equals SCAN_DIV-1, it wraps to 0 and the digit index increments mod 4.
  - an = ~(4'b0001 << index), registered.
  - seg = hex decode of DIGITS[4*index+3 : 4*index], active-low, updated in the same cycle as an.
  - Decode values: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E.
  - A DIGITS write is visible at the next digit activation that selects that nibble.
- MemRead and MemWrite both 1: the read returns the pre-write value and the write still commits.

Test Plan:
- Reset then release -> all readbacks 0; an=4'b1110; seg=8'hC0; Irq=0.
- Write TH=FFFF_FFFD, TL=FFFF_FFFE, then TCON=3 -> TL reads FFFF_FFFF one edge later and FFFF_FFFD the next edge; TCON reads 7; Irq=1; overflow repeats every 3 cycles.
- With Irq=1, write TCON=3 in the same cycle as an overflow -> TCON stays 7 and Irq stays 1. Write TCON=3 on a non-overflow cycle -> Irq=0 next cycle.
- Write DIGITS=16'h4321 with SCAN_DIV=16 -> an cycles 1110,1101,1011,0111 every 16 clks; seg shows F9, A4, B0, 99 respectively.
- Write TL=5 on the same edge as an enabled increment -> TL reads 5, then 6 the following cycle.
- Read 0x4000_0018, 0x4000_0002 and 0x0000_0010; write leds=0x1FF -> reads return 0 and leds=8'hFF. Then assert reset low mid-operation -> all state clears immediately, without waiting for a clk edge.
